// File: rtl/para_regs_mc_if.sv
// fx byte bus between the bus decoder (master) and a register bank (slave):
// one write byte and one read byte per cycle, read data registered in the slave.
interface para_regs_mc_if;
    logic        fx_wr;
    logic [21:0] fx_waddr;
    logic [7:0]  fx_data;
    logic        fx_rd;
    logic [21:0] fx_raddr;
    logic [7:0]  fx_q;

    modport master (output fx_wr, fx_waddr, fx_data, fx_rd, fx_raddr, input fx_q);
    modport slave  (input fx_wr, fx_waddr, fx_data, fx_rd, fx_raddr, output fx_q);
endinterface

// File: rtl/para_regs_mc.sv
// Multi-channel config/status register bank on the fx byte bus.
// Define PARA_REGS_MC_ATOMIC_EN for staged config commits and snapshotted status reads.
module para_regs_mc #(
    parameter int          NCH         = 4,
    parameter int          CFG_BYTES   = 4,
    parameter int          STA_BYTES   = 2,
    parameter logic [63:0] CFG_DEFAULT = 64'h8000
) (
    input  logic                       clk_sys,
    input  logic                       rst_n,
    input  logic [5:0]                 dev_id,
    para_regs_mc_if.slave              fx,
    input  logic [NCH*STA_BYTES*8-1:0] sta_in,
    output logic [NCH*CFG_BYTES*8-1:0] cfg_out,
    output logic [NCH-1:0]             cfg_upd
);

    localparam int CW = CFG_BYTES * 8;
    localparam int SW = STA_BYTES * 8;
    localparam logic [CW-1:0] CFG_RST = CFG_DEFAULT[CW-1:0];

    typedef enum logic [1:0] {REG_NONE, REG_CFG, REG_STA} reg_kind_e;
    typedef struct packed {
        reg_kind_e  kind;
        logic [3:0] ch;
        logic [2:0] idx;
    } dec_t;

    // Channel window 0x01c0..0x01cf: offsets 0-7 config bytes, 8-15 status bytes.
    function automatic dec_t decode(input logic [15:0] a);
        dec_t d;
        d.kind = REG_NONE;
        d.ch   = a[7:4];
        d.idx  = a[2:0];
        if (a[15:8] == 8'h01 && int'(a[7:4]) < NCH) begin
            if (!a[3] && int'(a[2:0]) < CFG_BYTES)     d.kind = REG_CFG;
            else if (a[3] && int'(a[2:0]) < STA_BYTES) d.kind = REG_STA;
        end
        return d;
    endfunction

    logic [CW-1:0] cfg_q [NCH];
    logic [CW-1:0] cfg_d [NCH];
    logic [NCH-1:0] cfg_upd_q, cfg_upd_d;
    logic [7:0]     fx_q_q, fx_q_d;

`ifdef PARA_REGS_MC_ATOMIC_EN
    // Byte 0 of status is always read live, so only bytes 1.. need a snapshot.
    localparam int SNAP_LO = (STA_BYTES > 1) ? 8 : 0;
    localparam int SNW     = (STA_BYTES > 1) ? SW - 8 : 8;
    logic [CW-1:0]  stg_q  [NCH];
    logic [CW-1:0]  stg_d  [NCH];
    logic [SNW-1:0] snap_q [NCH];
    logic [SNW-1:0] snap_d [NCH];
`endif

    logic w_sel, r_sel, soft_rst;
    dec_t wdec, rdec;

    assign w_sel    = fx.fx_wr && (fx.fx_waddr[21:16] == dev_id);
    assign r_sel    = fx.fx_rd && (fx.fx_raddr[21:16] == dev_id);
    assign wdec     = decode(fx.fx_waddr[15:0]);
    assign rdec     = decode(fx.fx_raddr[15:0]);
    assign soft_rst = w_sel && (fx.fx_waddr[15:0] == 16'h0004) && (fx.fx_data == 8'hA5);

    always_comb begin : next_state
        // NOTE: every next-state variable gets a default first so no path leaves it unassigned (no latch).
        cfg_d     = cfg_q;
        cfg_upd_d = '0;
`ifdef PARA_REGS_MC_ATOMIC_EN
        stg_d  = stg_q;
        snap_d = snap_q;
`endif
        if (w_sel && wdec.kind == REG_CFG) begin
            for (int c = 0; c < NCH; c++) begin
                if (wdec.ch == 4'(c)) begin
`ifdef PARA_REGS_MC_ATOMIC_EN
                    for (int k = 0; k < CFG_BYTES; k++)
                        if (wdec.idx == 3'(k)) stg_d[c][k*8 +: 8] = fx.fx_data;
                    // Top byte commits staging plus the new byte; staging keeps the same value.
                    if (int'(wdec.idx) == CFG_BYTES - 1) begin
                        cfg_d[c]     = stg_d[c];
                        cfg_upd_d[c] = 1'b1;
                    end
`else
                    for (int k = 0; k < CFG_BYTES; k++)
                        if (wdec.idx == 3'(k)) cfg_d[c][k*8 +: 8] = fx.fx_data;
                    cfg_upd_d[c] = 1'b1;
`endif
                end
            end
        end
`ifdef PARA_REGS_MC_ATOMIC_EN
        if (r_sel && rdec.kind == REG_STA && rdec.idx == 3'd0) begin
            for (int c = 0; c < NCH; c++)
                if (rdec.ch == 4'(c)) snap_d[c] = sta_in[c*SW + SNAP_LO +: SNW];
        end
`endif
        if (soft_rst) begin
            for (int c = 0; c < NCH; c++) begin
                cfg_d[c] = CFG_RST;
`ifdef PARA_REGS_MC_ATOMIC_EN
                stg_d[c]  = CFG_RST;
                snap_d[c] = '0;
`endif
            end
        end
    end

    // Read data is built from current state, so a same-cycle write or soft reset is not visible.
    always_comb begin : read_mux
        fx_q_d = '0;
        if (r_sel) begin
            if (fx.fx_raddr[15:0] == 16'h0000)      fx_q_d = {2'b00, dev_id};
            else if (fx.fx_raddr[15:0] == 16'h0001) fx_q_d = 8'(NCH);
            else if (fx.fx_raddr[15:0] == 16'h0002) fx_q_d = {4'(STA_BYTES), 4'(CFG_BYTES)};
            for (int c = 0; c < NCH; c++) begin
                if (rdec.ch == 4'(c)) begin
                    for (int k = 0; k < CFG_BYTES; k++)
                        if (rdec.kind == REG_CFG && rdec.idx == 3'(k)) fx_q_d = cfg_q[c][k*8 +: 8];
                    if (rdec.kind == REG_STA && rdec.idx == 3'd0) fx_q_d = sta_in[c*SW +: 8];
                    for (int k = 1; k < STA_BYTES; k++) begin
                        if (rdec.kind == REG_STA && rdec.idx == 3'(k)) begin
`ifdef PARA_REGS_MC_ATOMIC_EN
                            fx_q_d = snap_q[c][(k-1)*8 +: 8];
`else
                            fx_q_d = sta_in[c*SW + k*8 +: 8];
`endif
                        end
                    end
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments only; all blocking work stays in always_comb.
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            // NOTE: these arrays are architectural registers with defined reset values, not RAM, so they are reset.
            for (int c = 0; c < NCH; c++) begin
                cfg_q[c] <= CFG_RST;
`ifdef PARA_REGS_MC_ATOMIC_EN
                stg_q[c]  <= CFG_RST;
                snap_q[c] <= '0;
`endif
            end
            cfg_upd_q <= '0;
            fx_q_q    <= '0;
        end else begin
            cfg_q     <= cfg_d;
`ifdef PARA_REGS_MC_ATOMIC_EN
            stg_q     <= stg_d;
            snap_q    <= snap_d;
`endif
            cfg_upd_q <= cfg_upd_d;
            fx_q_q    <= fx_q_d;
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_cfg_out
        assign cfg_out[c*CW +: CW] = cfg_q[c];
    end
    assign cfg_upd = cfg_upd_q;
    assign fx.fx_q = fx_q_q;

endmodule
